// File: rtl/scytale_decryption.sv
// Scytale transposition decryptor: buffers ciphertext characters until the token,
// then streams them back out read column-major over the captured key_N x key_M matrix.
module scytale_decryption #(
  parameter int unsigned        D_WIDTH                = 8,
  parameter int unsigned        KEY_WIDTH              = 8,
  parameter int unsigned        MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned IDX_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int unsigned LEN_W = 2 * KEY_WIDTH;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     count_q;
  logic [KEY_WIDTH-1:0] key_n_q;
  logic [KEY_WIDTH-1:0] key_m_q;
  logic [KEY_WIDTH-1:0] row_q;
  logic [KEY_WIDTH-1:0] col_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     idx_q;
  logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];

  logic             done_c;
  logic             open_c;
  logic [CNT_W-1:0] cnt_eff_c;
  logic             is_char_c;
  logic             is_tok_c;
  logic             full_c;
  logic [LEN_W-1:0] len_c;
  logic             start_c;
  logic [LEN_W-1:0] rd_addr_c;

  // The final emit edge doubles as a collect edge with an empty buffer.
  always_comb begin
    done_c    = (state_q == EMIT) && (idx_q == len_q);
    open_c    = (state_q == COLLECT) || done_c;
    cnt_eff_c = done_c ? '0 : count_q;
    is_char_c = valid_i && open_c && (data_i != START_DECRYPTION_TOKEN);
    is_tok_c  = valid_i && open_c && (data_i == START_DECRYPTION_TOKEN);
    full_c    = (cnt_eff_c == CNT_W'(MAX_NOF_CHARS));
    len_c     = LEN_W'(key_N) * LEN_W'(key_M);
    start_c   = is_tok_c && (cnt_eff_c != '0) && (LEN_W'(cnt_eff_c) == len_c);
    rd_addr_c = LEN_W'(col_q) * LEN_W'(key_m_q) + LEN_W'(row_q);
  end

  // Character store; contents survive reset.
  always_ff @(posedge clk) begin
    if (is_char_c && !full_c)
      mem[IDX_W'(cnt_eff_c)] <= data_i;
  end

  // Control FSM; the first character is presented on the token edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      key_n_q <= '0;
      key_m_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else if (state_q == EMIT && !done_c) begin
      data_o <= mem[IDX_W'(rd_addr_c)];
      idx_q  <= idx_q + LEN_W'(1);
      if (col_q == key_n_q - KEY_WIDTH'(1)) begin
        col_q <= '0;
        row_q <= row_q + KEY_WIDTH'(1);
      end else begin
        col_q <= col_q + KEY_WIDTH'(1);
      end
    end else begin
      state_q <= COLLECT;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      count_q <= cnt_eff_c;
      if (is_char_c && !full_c)
        count_q <= cnt_eff_c + CNT_W'(1);
      if (is_tok_c) begin
        count_q <= '0;
        if (start_c) begin
          state_q <= EMIT;
          valid_o <= 1'b1;
          busy    <= 1'b1;
          data_o  <= mem[IDX_W'(0)];
          key_n_q <= key_N;
          key_m_q <= key_M;
          len_q   <= len_c;
          idx_q   <= LEN_W'(1);
          if (key_N == KEY_WIDTH'(1)) begin
            row_q <= KEY_WIDTH'(1);
          end else begin
            col_q <= KEY_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scytale_decryption.sv
// Directed self-checking bench for scytale_decryption.
module tb_scytale_decryption;

  localparam logic [7:0] TOK = 8'hFA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int total = 0;
  int bad   = 0;
  byte unsigned exp_q[$];
  byte unsigned drv_q[$];

  scytale_decryption dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .key_N  (key_N),
    .key_M  (key_M),
    .data_o (data_o),
    .valid_o(valid_o),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    valid_i = 1'b1;
    data_i  = c;
    tick();
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  // Checks one emitted character per cycle; drv_q entries are driven alongside.
  task automatic expect_stream(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(valid_o), 32'd1);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s_data%0d", tag, i), 32'(data_o), 32'(exp_q[i]));
      if (drv_q.size() > 0) begin
        valid_i = 1'b1;
        data_i  = drv_q.pop_front();
      end else begin
        valid_i = 1'b0;
        data_i  = 8'h00;
      end
      tick();
    end
    valid_i = 1'b0;
    data_i  = 8'h00;
    chk({tag, "_end_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_data"}, 32'(data_o), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_N   = 8'd2;
    key_M   = 8'd3;
    repeat (3) tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 2x3 decrypt.
    send_str("ACEBDF");
    send(TOK);
    load_exp("ABCDEF");
    expect_stream("basic");

    // Length mismatch is discarded, then a good message still works.
    send_str("ABCD");
    send(TOK);
    idle_check("mismatch", 4);
    send_str("ACEBDF");
    send(TOK);
    expect_stream("after_mismatch");

    // Input and key changes ignored while busy.
    send_str("ACEBDF");
    send(TOK);
    key_N = 8'd1;
    key_M = 8'd2;
    drv_q = '{8'h5A, 8'h5A, TOK};
    expect_stream("busy_block");
    key_N = 8'd2;
    key_M = 8'd3;
    idle_check("no_second", 4);

    // Back-to-back: first char of next message lands on the edge busy falls.
    send_str("ACEBDF");
    send(TOK);
    drv_q = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h61};
    expect_stream("b2b_first");
    send_str("cebdf");
    send(TOK);
    load_exp("abcdef");
    expect_stream("b2b_second");

    // Full buffer 5x10, 51st character dropped.
    key_N = 8'd5;
    key_M = 8'd10;
    for (int i = 0; i < 50; i++) send(8'(i));
    send(8'd99);
    send(TOK);
    exp_q.delete();
    for (int p = 0; p < 50; p++) exp_q.push_back(8'((p % 5) * 10 + p / 5));
    expect_stream("full");

    // Single-character message, then empty message with zero keys.
    key_N = 8'd1;
    key_M = 8'd1;
    send(8'h51);
    send(TOK);
    load_exp("Q");
    expect_stream("len1");
    key_N = 8'd0;
    key_M = 8'd0;
    send(TOK);
    idle_check("empty", 3);

    // Reset during emission aborts at once.
    key_N = 8'd2;
    key_M = 8'd3;
    send_str("ACEBDF");
    send(TOK);
    chk("mid_d0", 32'(data_o), 32'h41);
    tick();
    chk("mid_d1", 32'(data_o), 32'h42);
    tick();
    chk("mid_d2", 32'(data_o), 32'h43);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    tick();
    rst_n = 1'b1;
    idle_check("post_rst", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scytale_decryption.md
SCYTALE_DECRYPTION -- requirements
Module: scytale_decryption

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, character width in bits.
REQ-002 The block SHALL have parameter KEY_WIDTH, default 8, width of each key operand.
REQ-003 The block SHALL have parameter MAX_NOF_CHARS, default 50, character buffer depth.
REQ-004 The block SHALL have parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-message marker.
REQ-005 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port data_i  input  D_WIDTH  ciphertext character from the upstream byte demux lane.
REQ-008 The block SHALL have port valid_i  input  1  data_i qualifier, one character per high cycle.
REQ-009 The block SHALL have port key_N  input  KEY_WIDTH  column count of the scytale matrix.
REQ-010 The block SHALL have port key_M  input  KEY_WIDTH  row count of the scytale matrix.
REQ-011 The block SHALL have port data_o  output  D_WIDTH  decrypted character.
REQ-012 The block SHALL have port valid_o  output  1  data_o qualifier.
REQ-013 The block SHALL have port busy  output  1  high while a message is being emitted; input ignored.

Function
REQ-014 The block SHALL implement two states: COLLECT and EMIT.
REQ-015 In COLLECT, each edge with valid_i=1 and data_i != token SHALL write data_i to buf[count] and increment count.
REQ-016 Characters arriving when count == MAX_NOF_CHARS SHALL be dropped; count saturates at MAX_NOF_CHARS.
REQ-017 An edge in COLLECT with valid_i=1 and data_i == token SHALL capture key_N and key_M and set L = key_N*key_M, computed at 2*KEY_WIDTH bits.
REQ-018 On the token, if count == 0 or count != L, the message SHALL be discarded: no output, count cleared, state remains COLLECT.
REQ-019 On the token, if count == L, the state SHALL go to EMIT at the next edge, with row=0 and col=0; the token itself is never stored.
REQ-020 In EMIT, each cycle SHALL drive valid_o=1 and data_o = buf[col*key_M + row] using the captured keys.
REQ-021 After each emitted character, col SHALL increment; when col == key_N-1 it wraps to 0 and row increments.
REQ-022 Emitted character p (0..L-1) SHALL therefore equal buf[(p mod key_N)*key_M + p div key_N].
REQ-023 For a token accepted at edge T, valid_o and busy SHALL be high for exactly L consecutive cycles, from after edge T through edge T+L, with no gaps.
REQ-024 After the last character, both valid_o and busy SHALL fall at the same edge, count SHALL clear, and the state SHALL return to COLLECT.
REQ-025 valid_i SHALL be ignored while busy=1, whether the input is data or the token.
REQ-026 data_o SHALL be 0 whenever valid_o=0.
REQ-027 Changes on key_N and key_M during EMIT SHALL have no effect on the message in flight.
REQ-028 A character presented on the same edge that busy falls SHALL be accepted as the first character of the next message.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force data_o=0, valid_o=0, busy=0, count=0, row=0, col=0 and state COLLECT.
REQ-030 Buffer contents need not be cleared by reset.
REQ-031 Reset asserted during EMIT SHALL abort the message immediately; emission does not resume after rst_n rises.

Verification
REQ-032 Basic decrypt: key_N=2, key_M=3, input "ACEBDF" then 0xFA -> valid_o high 6 cycles, data_o "ABCDEF", busy high the same 6 cycles.
REQ-033 Length mismatch: key_N=2, key_M=3, input "ABCD" then 0xFA -> no valid_o, busy stays 0; next correct message still decrypts.
REQ-034 Busy blocking: during emission of REQ-032, drive valid_i=1 with "ZZ" and 0xFA -> output unchanged, no second message emitted.
REQ-035 Back-to-back: a second message whose first character lands on the edge busy falls -> both messages decrypted correctly.
REQ-036 Full buffer: key_N=5, key_M=10, 50 characters 0..49 then 0xFA -> 50 outputs in order buf[0], buf[10], buf[20], buf[30], buf[40], buf[1], ...; a 51st character sent before the token is dropped.
REQ-037 Reset mid-emit: assert rst_n=0 after the 3rd output of REQ-032 -> valid_o, busy and data_o go 0 at once; nothing further is emitted after release.
